// File: rtl/div_job_queue.sv
// Wishbone job queue for the serial divider: a job FIFO feeds a one-job-in-flight
// dispatch FSM, and quotient/remainder pairs return through a result FIFO.
module div_job_queue #(
  parameter int WBW   = 32,
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [WBW/8-1:0]   wbs_sel_i,
  input  logic [WBW-1:0]     wbs_adr_i,
  input  logic [WBW-1:0]     wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [WBW-1:0]     wbs_dat_o,
  output logic               div_start_o,
  output logic [XLEN-1:0]    div_dividend_o,
  output logic [XLEN-1:0]    div_divisor_o,
  input  logic               div_done_i,
  input  logic [XLEN-1:0]    div_quotient_i,
  input  logic [XLEN-1:0]    div_remainder_i,
  output logic               irq_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t             state_q, state_d;
  logic               ack_q, ack_d;
  logic [WBW-1:0]     dat_q, dat_d;
  logic               start_q, start_d;
  logic [XLEN-1:0]    dvd_q, dvd_d, dvs_q, dvs_d;
  logic [XLEN-1:0]    stage_q, stage_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;

  logic [XLEN-1:0]    job_dvd_q [DEPTH];
  logic [XLEN-1:0]    job_dvd_d [DEPTH];
  logic [XLEN-1:0]    job_dvs_q [DEPTH];
  logic [XLEN-1:0]    job_dvs_d [DEPTH];
  logic [AW-1:0]      job_wp_q, job_wp_d, job_rp_q, job_rp_d;
  logic [CW-1:0]      job_cnt_q, job_cnt_d;

  logic [XLEN-1:0]    res_quo_q [DEPTH];
  logic [XLEN-1:0]    res_quo_d [DEPTH];
  logic [XLEN-1:0]    res_rem_q [DEPTH];
  logic [XLEN-1:0]    res_rem_d [DEPTH];
  logic [AW-1:0]      res_wp_q, res_wp_d, res_rp_q, res_rp_d;
  logic [CW-1:0]      res_cnt_q, res_cnt_d;

  logic               wb_go;
  logic [2:0]         wb_off;
  logic               job_full, job_empty, res_full, res_empty;
  logic               job_push, job_pop, res_push, res_pop;
  logic [WBW-1:0]     status;
  logic               unused_ok;

  assign wb_go     = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wb_off    = wbs_adr_i[4:2];
  assign job_full  = (job_cnt_q == CW'(DEPTH));
  assign job_empty = (job_cnt_q == '0);
  assign res_full  = (res_cnt_q == CW'(DEPTH));
  assign res_empty = (res_cnt_q == '0);
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

  always_comb begin
    status           = '0;
    status[0]        = job_full;
    status[1]        = job_empty;
    status[2]        = res_full;
    status[3]        = res_empty;
    status[4]        = (state_q != ST_IDLE);
    status[5]        = ovf_q;
    status[6]        = unf_q;
    status[8 +: CW]  = job_cnt_q;
    status[16 +: CW] = res_cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    dat_d     = dat_q;
    start_d   = 1'b0;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    stage_d   = stage_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    job_dvd_d = job_dvd_q;
    job_dvs_d = job_dvs_q;
    job_wp_d  = job_wp_q;
    job_rp_d  = job_rp_q;
    job_cnt_d = job_cnt_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    res_wp_d  = res_wp_q;
    res_rp_d  = res_rp_q;
    res_cnt_d = res_cnt_q;
    job_push  = 1'b0;
    job_pop   = 1'b0;
    res_push  = 1'b0;
    res_pop   = 1'b0;

    // Register access: side effects and read data land on the edge that raises ack.
    if (wb_go) begin
      ack_d = 1'b1;
      dat_d = '0;
      case (wb_off)
        3'd0: begin
          if (wbs_we_i) stage_d = wbs_dat_i[XLEN-1:0];
          else          dat_d[XLEN-1:0] = stage_q;
        end
        3'd1: begin
          if (wbs_we_i) begin
            if (job_full) ovf_d = 1'b1;
            else          job_push = 1'b1;
          end
        end
        3'd2: begin
          if (!wbs_we_i && !res_empty) dat_d[XLEN-1:0] = res_quo_q[res_rp_q];
        end
        3'd3: begin
          if (!wbs_we_i) begin
            if (res_empty) unf_d = 1'b1;
            else begin
              dat_d[XLEN-1:0] = res_rem_q[res_rp_q];
              res_pop = 1'b1;
            end
          end
        end
        3'd4: begin
          if (wbs_we_i) begin
            if (wbs_dat_i[5]) ovf_d = 1'b0;
            if (wbs_dat_i[6]) unf_d = 1'b0;
          end else begin
            dat_d = status;
          end
        end
        default: dat_d = '0;
      endcase
    end

    // Dispatch only when a result slot is free, so the WAIT push can never overflow.
    case (state_q)
      ST_IDLE: begin
        if (!job_empty && !res_full) begin
          state_d = ST_ISSUE;
          start_d = 1'b1;
          dvd_d   = job_dvd_q[job_rp_q];
          dvs_d   = job_dvs_q[job_rp_q];
        end
      end
      ST_ISSUE: begin
        job_pop = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_done_i) begin
          res_push = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (job_push) begin
      job_dvd_d[job_wp_q] = stage_q;
      job_dvs_d[job_wp_q] = wbs_dat_i[XLEN-1:0];
      job_wp_d            = job_wp_q + AW'(1);
    end
    if (job_pop) job_rp_d = job_rp_q + AW'(1);
    if (job_push && !job_pop)      job_cnt_d = job_cnt_q + CW'(1);
    else if (!job_push && job_pop) job_cnt_d = job_cnt_q - CW'(1);

    if (res_push) begin
      res_quo_d[res_wp_q] = div_quotient_i;
      res_rem_d[res_wp_q] = div_remainder_i;
      res_wp_d            = res_wp_q + AW'(1);
    end
    if (res_pop) res_rp_d = res_rp_q + AW'(1);
    if (res_push && !res_pop)      res_cnt_d = res_cnt_q + CW'(1);
    else if (!res_push && res_pop) res_cnt_d = res_cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      start_q   <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      stage_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      job_wp_q  <= '0;
      job_rp_q  <= '0;
      job_cnt_q <= '0;
      res_wp_q  <= '0;
      res_rp_q  <= '0;
      res_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        job_dvd_q[i] <= '0;
        job_dvs_q[i] <= '0;
        res_quo_q[i] <= '0;
        res_rem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      start_q   <= start_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      stage_q   <= stage_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      job_wp_q  <= job_wp_d;
      job_rp_q  <= job_rp_d;
      job_cnt_q <= job_cnt_d;
      res_wp_q  <= res_wp_d;
      res_rp_q  <= res_rp_d;
      res_cnt_q <= res_cnt_d;
      job_dvd_q <= job_dvd_d;
      job_dvs_q <= job_dvs_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign div_start_o    = start_q;
  assign div_dividend_o = dvd_q;
  assign div_divisor_o  = dvs_q;
  assign irq_o          = !res_empty;

endmodule

// File: tb/tb_div_job_queue.sv
// Directed bench for div_job_queue: a behavioural divider core plus a scoreboard
// of expected quotient/remainder pairs checked as firmware drains results.
module tb_div_job_queue;

  localparam int WBW   = 32;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } res_t;

  logic              clk = 1'b0;
  logic              reset_ni;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [WBW/8-1:0]  wbs_sel_i;
  logic [WBW-1:0]    wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [WBW-1:0]    wbs_dat_o;
  logic              div_start_o;
  logic [XLEN-1:0]   div_dividend_o, div_divisor_o;
  logic              div_done_i;
  logic [XLEN-1:0]   div_quotient_i, div_remainder_i;
  logic              irq_o;

  int total = 0;
  int bad   = 0;
  res_t sb[$];

  logic        model_en = 1'b1;
  logic        stall    = 1'b0;
  int          latency  = 33;
  int          starts   = 0;
  logic        m_done   = 1'b0;
  logic [31:0] m_q = '0, m_r = '0;
  logic        man_done = 1'b0;
  logic [31:0] man_q = '0, man_r = '0;

  assign div_done_i      = model_en ? m_done : man_done;
  assign div_quotient_i  = model_en ? m_q : man_q;
  assign div_remainder_i = model_en ? m_r : man_r;

  always #5 clk = ~clk;

  div_job_queue #(.WBW(WBW), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .div_start_o(div_start_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_done_i(div_done_i),
    .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
    .irq_o(irq_o)
  );

  // Behavioural divider core: answers `latency` unstalled cycles after each start.
  initial begin : core_model
    int cnt;
    logic [31:0] a, b;
    cnt = 0; a = '0; b = '0;
    forever begin
      @(posedge clk); #1;
      m_done = 1'b0;
      if (div_start_o) begin
        starts++;
        a = div_dividend_o;
        b = div_divisor_o;
        cnt = latency;
      end else if (cnt > 0 && !stall) begin
        cnt--;
        if (cnt == 0) begin
          m_done = 1'b1;
          m_q = (b != 0) ? a / b : '1;
          m_r = (b != 0) ? a % b : a;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input bit jf, je, rf, re, busy, ovf, unf, input int jc, input int rc);
    return {8'd0, 8'(rc), 8'(jc), 1'b0, unf, ovf, busy, re, rf, je, jf};
  endfunction

  task automatic wb_access(input logic we, input logic [2:0] off, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    int n;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = {27'd0, off, 2'b00}; wbs_dat_i = wdata;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!wbs_ack_o && n < 4);
    rdata = wbs_dat_o;
    check_output($sformatf("ack_latency_off%0d", off), 64'(n), 64'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    tick(1);
  endtask

  task automatic wb_write(input logic [2:0] off, input logic [31:0] wdata);
    logic [31:0] dummy;
    wb_access(1'b1, off, wdata, dummy);
  endtask

  task automatic read_check(input string tag, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    wb_access(1'b0, off, 32'd0, rd);
    check_output(tag, 64'(rd), 64'(exp));
  endtask

  task automatic post_job(input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    res_t e;
    wb_write(3'd0, a);
    wb_write(3'd1, b);
    if (expect_result) begin
      e.q = a / b;
      e.r = a % b;
      sb.push_back(e);
    end
  endtask

  task automatic read_result(input string tag);
    logic [31:0] rq, rr;
    if (sb.size() == 0) begin
      bad++;
      total++;
      $error("[TB] FAIL %s: scoreboard empty, observed=0 expected=1 entries", tag);
    end else begin
      wb_access(1'b0, 3'd2, 32'd0, rq);
      check_output({tag, "_quot"}, 64'(rq), 64'(sb[0].q));
      wb_access(1'b0, 3'd3, 32'd0, rr);
      check_output({tag, "_rem"}, 64'(rr), 64'(sb[0].r));
      void'(sb.pop_front());
    end
  endtask

  task automatic pulse_done(input logic [31:0] a, input logic [31:0] b);
    man_done = 1'b1; man_q = a / b; man_r = a % b;
    tick(1);
    man_done = 1'b0;
  endtask

  initial begin : stimulus
    int n, base;
    reset_ni = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '1; wbs_adr_i = '0; wbs_dat_i = '0;
    tick(3);

    check_output("rst_ack", 64'(wbs_ack_o), 64'd0);
    check_output("rst_dat", 64'(wbs_dat_o), 64'd0);
    check_output("rst_start", 64'(div_start_o), 64'd0);
    check_output("rst_irq", 64'(irq_o), 64'd0);
    reset_ni = 1'b1;
    tick(1);
    read_check("rst_status", 3'd4, st(0, 1, 0, 1, 0, 0, 0, 0, 0));

    $display("[TB] single job");
    latency = 33;
    post_job(32'd100, 32'd7, 1'b1);
    check_output("single_start", 64'(div_start_o), 64'd1);
    check_output("single_dividend", 64'(div_dividend_o), 64'd100);
    check_output("single_divisor", 64'(div_divisor_o), 64'd7);
    n = 0;
    while (!irq_o && n < 100) begin
      tick(1);
      n++;
    end
    check_output("single_irq_high", 64'(irq_o), 64'd1);
    read_result("single");
    read_check("single_status", 3'd4, st(0, 1, 0, 1, 0, 0, 0, 0, 0));
    check_output("single_irq_low", 64'(irq_o), 64'd0);

    $display("[TB] overflow and result backpressure");
    latency = 5;
    stall = 1'b1;
    base = starts;
    for (int i = 0; i < 6; i++) post_job(32'(1000 + i * 37), 32'(i + 3), i < 5);
    read_check("ovf_status", 3'd4, st(1, 0, 0, 1, 1, 1, 0, 4, 0));
    wb_write(3'd4, 32'h20);
    read_check("ovf_cleared", 3'd4, st(1, 0, 0, 1, 1, 0, 0, 4, 0));
    stall = 1'b0;
    tick(150);
    read_check("bp_status", 3'd4, st(0, 0, 1, 0, 0, 0, 0, 1, 4));
    check_output("bp_no_fifth_start", 64'(starts - base), 64'd4);
    read_result("bp_res0");
    check_output("bp_restart", 64'(div_start_o), 64'd1);
    tick(20);
    for (int i = 1; i < 5; i++) read_result($sformatf("bp_res%0d", i));
    check_output("bp_total_starts", 64'(starts - base), 64'd5);
    read_check("bp_drained", 3'd4, st(0, 1, 0, 1, 0, 0, 0, 0, 0));

    $display("[TB] underflow and decode");
    read_check("unf_rem", 3'd3, 32'd0);
    read_check("unf_status", 3'd4, st(0, 1, 0, 1, 0, 0, 1, 0, 0));
    read_check("empty_quot", 3'd2, 32'd0);
    read_check("divisor_read", 3'd1, 32'd0);
    read_check("off6_read", 3'd6, 32'd0);
    wb_write(3'd6, 32'hFFFF_FFFF);
    wb_write(3'd2, 32'h1234);
    read_check("ro_write_ignored", 3'd4, st(0, 1, 0, 1, 0, 0, 1, 0, 0));
    wb_write(3'd4, 32'h40);
    read_check("unf_cleared", 3'd4, st(0, 1, 0, 1, 0, 0, 0, 0, 0));

    $display("[TB] concurrent push and pop");
    model_en = 1'b0;
    post_job(32'd10, 32'd3, 1'b1);
    check_output("conc_start0", 64'(div_start_o), 64'd1);
    tick(1);
    pulse_done(32'd10, 32'd3);
    post_job(32'd20, 32'd3, 1'b1);
    check_output("conc_start1", 64'(div_start_o), 64'd1);
    tick(1);
    pulse_done(32'd20, 32'd3);
    post_job(32'd30, 32'd3, 1'b1);
    check_output("conc_start2", 64'(div_start_o), 64'd1);
    tick(1);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = {27'd0, 3'd3, 2'b00};
    man_done = 1'b1; man_q = 32'd30 / 32'd3; man_r = 32'd30 % 32'd3;
    tick(1);
    man_done = 1'b0;
    check_output("conc_ack", 64'(wbs_ack_o), 64'd1);
    check_output("conc_old_head", 64'(wbs_dat_o), 64'(sb[0].r));
    void'(sb.pop_front());
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick(1);
    read_check("conc_count", 3'd4, st(0, 1, 0, 0, 0, 0, 0, 0, 2));
    read_result("conc_second");
    read_result("conc_third");

    $display("[TB] reset during WAIT");
    post_job(32'd50, 32'd5, 1'b0);
    check_output("rstw_start", 64'(div_start_o), 64'd1);
    tick(2);
    reset_ni = 1'b0;
    #1;
    check_output("rstw_ack", 64'(wbs_ack_o), 64'd0);
    check_output("rstw_dat", 64'(wbs_dat_o), 64'd0);
    check_output("rstw_start_low", 64'(div_start_o), 64'd0);
    check_output("rstw_dividend", 64'(div_dividend_o), 64'd0);
    check_output("rstw_divisor", 64'(div_divisor_o), 64'd0);
    tick(1);
    reset_ni = 1'b1;
    tick(1);
    pulse_done(32'd50, 32'd5);
    tick(2);
    check_output("rstw_irq", 64'(irq_o), 64'd0);
    check_output("rstw_no_start", 64'(div_start_o), 64'd0);
    read_check("rstw_status", 3'd4, st(0, 1, 0, 1, 0, 0, 0, 0, 0));
    read_check("rstw_staging", 3'd0, 32'd0);
    check_output("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
